// File: rtl/puf_ctrl_pkg.sv
// Shared types and constants for the PUF challenge sequencer.
package puf_ctrl_pkg;

    localparam int unsigned CHAL_BYTES = 8;
    localparam int unsigned CHAL_W     = 64;

    typedef enum logic [1:0] {
        StRecv,
        StPreset,
        StFire,
        StSend
    } seq_state_e;

endpackage

// File: rtl/puf_settle_timer.sv
// Settle interval timer: `done` pulses for one cycle SETTLE_CYCLES cycles after `start`.
// A new `start` restarts the count, so one instance serves back-to-back phases.
module puf_settle_timer #(
    parameter int unsigned SETTLE_CYCLES = 65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic done
);

    localparam int unsigned CntW = $clog2(SETTLE_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            active_q, active_d;

    always_comb begin
        done     = active_q && (cnt_q == CntW'(SETTLE_CYCLES - 1));
        cnt_d    = cnt_q;
        active_d = active_q;
        if (start) begin
            cnt_d    = '0;
            active_d = 1'b1;
        end else if (done) begin
            active_d = 1'b0;
        end else if (active_q) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Collects an 8-byte challenge, runs one arbiter-PUF evaluation and streams the response out.
// Optional PUF_SEQ_TAG_EN prefixes each response frame with a wrapping 8-bit sequence tag.
module puf_challenge_sequencer
    import puf_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    output logic [CHAL_W-1:0] puf_challenge,
    output logic              puf_signal,
    input  logic [CHAL_W-1:0] puf_response,
    output logic              busy
);

`ifdef PUF_SEQ_TAG_EN
    localparam int unsigned FrameBytes = CHAL_BYTES + 1;
`else
    localparam int unsigned FrameBytes = CHAL_BYTES;
`endif
    localparam int unsigned ByteCntW = $clog2(CHAL_BYTES);
    localparam int unsigned SendCntW = $clog2(FrameBytes + 1);

    seq_state_e          state_q, state_d;
    logic                rx_prev_q;
    logic [ByteCntW-1:0] byte_cnt_q, byte_cnt_d;
    logic [CHAL_W-1:0]   asm_q, asm_d;
    logic [CHAL_W-1:0]   chal_q, chal_d;
    logic [CHAL_W-1:0]   shift_q, shift_d;
    logic [SendCntW-1:0] send_cnt_q, send_cnt_d;
    logic                tx_valid_q, tx_valid_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                puf_signal_q, puf_signal_d;
    logic                timer_start, timer_done;
    logic                rx_rise, xfer;
    logic [CHAL_W-1:0]   asm_shifted;
`ifdef PUF_SEQ_TAG_EN
    logic [7:0]          tag_q, tag_d;
`endif

    puf_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .start(timer_start),
        .done (timer_done)
    );

    assign rx_rise     = rx_valid && !rx_prev_q;
    assign xfer        = tx_valid_q && tx_ready;
    assign asm_shifted = {asm_q[CHAL_W-9:0], rx_data};

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        asm_d       = asm_q;
        chal_d      = chal_q;
        shift_d     = shift_q;
        send_cnt_d  = send_cnt_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;
        timer_start = 1'b0;
`ifdef PUF_SEQ_TAG_EN
        tag_d       = tag_q;
`endif
        case (state_q)
            StRecv: begin
                if (rx_rise) begin
                    asm_d      = asm_shifted;
                    byte_cnt_d = byte_cnt_q + ByteCntW'(1);
                    if (byte_cnt_q == ByteCntW'(CHAL_BYTES - 1)) begin
                        chal_d      = asm_shifted;
                        byte_cnt_d  = '0;
                        state_d     = StPreset;
                        timer_start = 1'b1;
                    end
                end
            end
            StPreset: begin
                if (timer_done) begin
                    state_d     = StFire;
                    timer_start = 1'b1;
                end
            end
            StFire: begin
                if (timer_done) begin
                    state_d    = StSend;
                    send_cnt_d = '0;
                    tx_valid_d = 1'b1;
`ifdef PUF_SEQ_TAG_EN
                    tx_data_d  = tag_q;
                    shift_d    = puf_response;
`else
                    tx_data_d  = puf_response[CHAL_W-1 -: 8];
                    shift_d    = puf_response << 8;
`endif
                end
            end
            StSend: begin
                if (xfer) begin
                    tx_data_d = shift_q[CHAL_W-1 -: 8];
                    shift_d   = shift_q << 8;
                    if (send_cnt_q == SendCntW'(FrameBytes - 1)) begin
                        tx_valid_d = 1'b0;
                        send_cnt_d = '0;
                        state_d    = StRecv;
`ifdef PUF_SEQ_TAG_EN
                        tag_d      = tag_q + 8'd1;
`endif
                    end else begin
                        send_cnt_d = send_cnt_q + SendCntW'(1);
                    end
                end
            end
            default: state_d = StRecv;
        endcase
        // Registered so the race input is high exactly during the FIRE cycles.
        puf_signal_d = (state_d == StFire);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StRecv;
            rx_prev_q    <= 1'b0;
            byte_cnt_q   <= '0;
            asm_q        <= '0;
            chal_q       <= '0;
            shift_q      <= '0;
            send_cnt_q   <= '0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            puf_signal_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_prev_q    <= rx_valid;
            byte_cnt_q   <= byte_cnt_d;
            asm_q        <= asm_d;
            chal_q       <= chal_d;
            shift_q      <= shift_d;
            send_cnt_q   <= send_cnt_d;
            tx_valid_q   <= tx_valid_d;
            tx_data_q    <= tx_data_d;
            puf_signal_q <= puf_signal_d;
        end
    end

`ifdef PUF_SEQ_TAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= 8'h00;
        end else begin
            tag_q <= tag_d;
        end
    end
`endif

    assign tx_valid      = tx_valid_q;
    assign tx_data       = tx_data_q;
    assign puf_challenge = chal_q;
    assign puf_signal    = puf_signal_q;
    assign busy          = (state_q != StRecv);

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Directed bench for puf_challenge_sequencer with SETTLE_CYCLES=4.
// Honours PUF_SEQ_TAG_EN when defined (adds the 257-frame tag run).
module tb_puf_challenge_sequencer;

    localparam int S = 4;
`ifdef PUF_SEQ_TAG_EN
    localparam int TagOff = 1;
`else
    localparam int TagOff = 0;
`endif
    localparam int FB = 8 + TagOff;

    logic        clk, rst_n, rx_valid, tx_ready, tx_valid, puf_signal, busy;
    logic [7:0]  rx_data, tx_data;
    logic [63:0] puf_challenge, puf_response;
    int          vectors, errors;
    logic [7:0]  exp_tag;

    puf_challenge_sequencer #(
        .SETTLE_CYCLES(S)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .tx_ready     (tx_ready),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .puf_challenge(puf_challenge),
        .puf_signal   (puf_signal),
        .puf_response (puf_response),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] frame_byte(input logic [63:0] r, input int i);
        int j;
        j = i - TagOff;
        if (j < 0) return exp_tag;
        return r[63-8*j -: 8];
    endfunction

    task automatic send_byte(input logic [7:0] b, input int hold);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        repeat (hold) @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [63:0] c);
        for (int i = 0; i < 8; i++) send_byte(c[63-8*i -: 8], 1);
    endtask

    // Collects one response frame; optionally stalls tx_ready at byte index stall_at.
    task automatic drain(input logic [63:0] resp, input int stall_at, input int stall_len);
        int sent, stalled, budget;
        sent = 0; stalled = 0; budget = 0;
        tx_ready = 1'b1;
        while (sent < FB && budget < 300) begin
            @(negedge clk);
            budget++;
            if (sent == stall_at && stalled < stall_len && (stalled > 0 || tx_valid)) begin
                vectors++;
                if (tx_valid !== 1'b1 || tx_data !== frame_byte(resp, sent)) begin
                    errors++;
                    $display("FAIL stall_hold[%0d]: got valid=%b data=%h want valid=1 data=%h",
                             stalled, tx_valid, tx_data, frame_byte(resp, sent));
                end
                tx_ready = 1'b0;
                stalled++;
            end else if (tx_valid) begin
                tx_ready = 1'b1;
                vectors++;
                if (tx_data !== frame_byte(resp, sent)) begin
                    errors++;
                    $display("FAIL tx_byte[%0d]: got %h want %h", sent, tx_data,
                             frame_byte(resp, sent));
                end
                sent++;
            end
        end
        vectors++;
        if (sent != FB) begin
            errors++;
            $display("FAIL drain_count: got %0d bytes want %0d", sent, FB);
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_frame_idle: got busy=%b valid=%b want 0 0", busy, tx_valid);
        end
        exp_tag++;
        tx_ready = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00 || puf_challenge !== 64'h0 ||
            puf_signal !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b data=%h chal=%h sig=%b busy=%b want all 0",
                     tx_valid, tx_data, puf_challenge, puf_signal, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_basic();
        logic [63:0] resp;
        logic        exp_sig, exp_val;
        resp         = 64'h0123456789ABCDEF;
        puf_response = resp;
        tx_ready     = 1'b1;
        send_frame(64'hE5F2803E30E0B4BC);
        // Now sampling cycle N+1.
        vectors++;
        if (puf_challenge !== 64'hE5F2803E30E0B4BC) begin
            errors++;
            $display("FAIL basic_challenge: got %h want E5F2803E30E0B4BC", puf_challenge);
        end
        for (int k = 1; k <= 2 * S + FB + 1; k++) begin
            if (k > 1) @(negedge clk);
            exp_sig = (k >= S + 1 && k <= 2 * S);
            exp_val = (k >= 2 * S + 1 && k <= 2 * S + FB);
            vectors++;
            if (puf_signal !== exp_sig) begin
                errors++;
                $display("FAIL basic_signal@N+%0d: got %b want %b", k, puf_signal, exp_sig);
            end
            vectors++;
            if (tx_valid !== exp_val) begin
                errors++;
                $display("FAIL basic_valid@N+%0d: got %b want %b", k, tx_valid, exp_val);
            end
            vectors++;
            if (busy !== (k <= 2 * S + FB)) begin
                errors++;
                $display("FAIL basic_busy@N+%0d: got %b want %b", k, busy, (k <= 2 * S + FB));
            end
            if (exp_val) begin
                vectors++;
                if (tx_data !== frame_byte(resp, k - 2 * S - 1)) begin
                    errors++;
                    $display("FAIL basic_data@N+%0d: got %h want %h", k, tx_data,
                             frame_byte(resp, k - 2 * S - 1));
                end
            end
        end
        exp_tag++;
    endtask

    task automatic test_backpressure();
        puf_response = 64'h0123456789ABCDEF;
        send_frame(64'h0011223344556677);
        drain(puf_response, 2 + TagOff, 3);
    endtask

    task automatic test_hold();
        int busy_cycles;
        puf_response = 64'h13579BDF2468ACE0;
        send_byte(8'hAA, 5);
        for (int i = 1; i < 8; i++) send_byte(8'(i), 1);
        vectors++;
        if (puf_challenge !== 64'hAA01020304050607) begin
            errors++;
            $display("FAIL hold_challenge: got %h want AA01020304050607", puf_challenge);
        end
        drain(puf_response, -1, 0);
        busy_cycles = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy) busy_cycles++;
        end
        vectors++;
        if (busy_cycles != 0) begin
            errors++;
            $display("FAIL hold_single_eval: got %0d busy cycles want 0", busy_cycles);
        end
    endtask

    task automatic test_fire_pulse();
        puf_response = 64'hA5A5A5A55A5A5A5A;
        send_frame(64'h0102030405060708);
        repeat (S + 1) @(negedge clk);
        vectors++;
        if (puf_signal !== 1'b1) begin
            errors++;
            $display("FAIL fire_phase: got sig=%b want 1", puf_signal);
        end
        send_byte(8'h5A, 1);
        drain(puf_response, -1, 0);
        puf_response = 64'h0F0E0D0C0B0A0908;
        send_frame(64'h8877665544332211);
        vectors++;
        if (puf_challenge !== 64'h8877665544332211) begin
            errors++;
            $display("FAIL fire_next_challenge: got %h want 8877665544332211", puf_challenge);
        end
        drain(puf_response, -1, 0);
    endtask

    task automatic test_reset_mid();
        int sent, budget;
        sent = 0; budget = 0;
        puf_response = 64'hFEDCBA9876543210;
        tx_ready     = 1'b1;
        send_frame(64'h1122334455667788);
        while (sent < 3 && budget < 100) begin
            @(negedge clk);
            budget++;
            if (tx_valid) sent++;
        end
        vectors++;
        if (sent != 3) begin
            errors++;
            $display("FAIL reset_mid_wait: got %0d bytes want 3", sent);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00 || puf_challenge !== 64'h0 ||
            puf_signal !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got valid=%b data=%h chal=%h sig=%b busy=%b want all 0",
                     tx_valid, tx_data, puf_challenge, puf_signal, busy);
        end
        exp_tag = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'h99, 1);
        send_byte(8'h98, 1);
        send_byte(8'h97, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL partial_reset_idle: got busy=%b want 0", busy);
        end
        puf_response = 64'h0F1E2D3C4B5A6978;
        send_frame(64'hC0FFEE0012345678);
        vectors++;
        if (puf_challenge !== 64'hC0FFEE0012345678) begin
            errors++;
            $display("FAIL fresh_challenge: got %h want C0FFEE0012345678", puf_challenge);
        end
        drain(puf_response, -1, 0);
    endtask

`ifdef PUF_SEQ_TAG_EN
    task automatic test_tags();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        exp_tag = 8'h00;
        for (int f = 0; f < 257; f++) begin
            puf_response = {8{f[7:0]}} ^ 64'h5A5AC3C30F0FF00F;
            send_frame(64'h1000 + 64'(f));
            drain(puf_response, -1, 0);
        end
    endtask
`endif

    initial begin
        clk          = 1'b0;
        rst_n        = 1'b0;
        rx_valid     = 1'b0;
        rx_data      = 8'h00;
        tx_ready     = 1'b1;
        puf_response = 64'h0;
        vectors      = 0;
        errors       = 0;
        exp_tag      = 8'h00;
        test_reset();
        test_basic();
        test_backpressure();
        test_hold();
        test_fire_pulse();
        test_reset_mid();
`ifdef PUF_SEQ_TAG_EN
        test_tags();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
